// File: rtl/mme_top.sv
// 4x4 matrix-multiply engine: C = A(4xW) x B(Wx4) on signed 32-bit words.
// Configured over APB; fetches operands and writes the result as an AXI3 master.
module mme_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR_AW, WR_W, WR_B} state_t;

    state_t      state_r, next_s;
    logic [31:0] cfg_r, a_addr_r, b_addr_r, c_addr_r;
    logic        status_r;
    logic [7:0]  w_r, k_r;
    logic [31:0] a_base_r, b_base_r, c_base_r;
    logic [31:0] a_col_r [4];
    logic [31:0] b_row_r [4];
    logic [31:0] acc_r [16];
    logic [3:0]  beat_r;
    logic        arvalid_r, awvalid_r, wvalid_r;
    logic        apb_wr_s, start_s, r_fire_s, w_fire_s, last_k_s;
    logic        unused_s;

    assign apb_wr_s = psel & penable & pwrite;
    assign start_s  = apb_wr_s && (paddr == 32'h0000_020C) && pwdata[0] && (state_r == IDLE);
    assign r_fire_s = rvalid && rready;
    assign w_fire_s = wvalid_r && wready;
    assign last_k_s = (({1'b0, k_r} + 9'd1) >= {1'b0, w_r});
    assign unused_s = ^{rid, rresp, rlast, bid, bresp};

    assign pready  = 1'b1;
    assign pslverr = 1'b0;
    assign arid    = 4'd0;
    assign arlen   = 4'd3;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = arvalid_r;
    assign araddr  = ((state_r == RD_B) ? b_base_r : a_base_r) + {20'd0, k_r, 4'd0};
    assign rready  = (state_r == RD_A) || (state_r == RD_B);
    assign awid    = 4'd0;
    assign awaddr  = c_base_r;
    assign awlen   = 4'd15;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awvalid = awvalid_r;
    assign wid     = 4'd0;
    assign wdata   = acc_r[beat_r];
    assign wstrb   = 4'hF;
    assign wlast   = (beat_r == 4'd15);
    assign wvalid  = wvalid_r;
    assign bready  = (state_r == WR_B);

    // Host-visible configuration registers and the done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_r    <= 32'd0;
            a_addr_r <= 32'd0;
            b_addr_r <= 32'd0;
            c_addr_r <= 32'd0;
            status_r <= 1'b1;
        end else begin
            if (apb_wr_s) begin
                case (paddr)
                    32'h0000_0100: cfg_r    <= pwdata;
                    32'h0000_0200: a_addr_r <= pwdata;
                    32'h0000_0204: b_addr_r <= pwdata;
                    32'h0000_0208: c_addr_r <= pwdata;
                    default:       cfg_r    <= cfg_r;
                endcase
            end
            if (start_s) begin
                status_r <= 1'b0;
            end else if ((state_r == WR_B) && bvalid) begin
                status_r <= 1'b1;
            end
        end
    end

    // APB read mux
    always_comb begin
        prdata = 32'd0;
        if (psel) begin
            case (paddr)
                32'h0000_0000: prdata = 32'h0001_0000;
                32'h0000_0100: prdata = cfg_r;
                32'h0000_0200: prdata = a_addr_r;
                32'h0000_0204: prdata = b_addr_r;
                32'h0000_0208: prdata = c_addr_r;
                32'h0000_0210: prdata = {31'd0, status_r};
                default:       prdata = 32'd0;
            endcase
        end else begin
            prdata = 32'd0;
        end
    end

    // Engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Engine next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:  if (start_s) next_s = (cfg_r[7:0] == 8'd0) ? WR_AW : RD_A;
                   else next_s = IDLE;
            RD_A:  if (r_fire_s && (beat_r == 4'd3)) next_s = RD_B;
                   else next_s = RD_A;
            RD_B:  if (r_fire_s && (beat_r == 4'd3)) next_s = MAC;
                   else next_s = RD_B;
            MAC:   if (last_k_s) next_s = WR_AW;
                   else next_s = RD_A;
            WR_AW: if (awvalid_r && awready) next_s = WR_W;
                   else next_s = WR_AW;
            WR_W:  if (w_fire_s && (beat_r == 4'd15)) next_s = WR_B;
                   else next_s = WR_W;
            WR_B:  if (bvalid) next_s = IDLE;
                   else next_s = WR_B;
            default: next_s = IDLE;
        endcase
    end

    // Job snapshot, operand capture, accumulation and channel valids
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r       <= 8'd0;
            k_r       <= 8'd0;
            a_base_r  <= 32'd0;
            b_base_r  <= 32'd0;
            c_base_r  <= 32'd0;
            beat_r    <= 4'd0;
            arvalid_r <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_col_r[i] <= 32'd0;
                b_row_r[i] <= 32'd0;
            end
            for (int i = 0; i < 16; i++) acc_r[i] <= 32'd0;
        end else begin
            if (start_s) begin
                w_r      <= cfg_r[7:0];
                k_r      <= 8'd0;
                a_base_r <= a_addr_r;
                b_base_r <= b_addr_r;
                c_base_r <= c_addr_r;
                for (int i = 0; i < 16; i++) acc_r[i] <= 32'd0;
            end
            // beat index restarts on every state change; it counts R or W handshakes
            if (next_s != state_r) beat_r <= 4'd0;
            else if (r_fire_s || w_fire_s) beat_r <= beat_r + 4'd1;
            if ((state_r == RD_A) && r_fire_s) a_col_r[beat_r[1:0]] <= rdata;
            if ((state_r == RD_B) && r_fire_s) b_row_r[beat_r[1:0]] <= rdata;
            if (state_r == MAC) begin
                for (int i = 0; i < 16; i++) acc_r[i] <= acc_r[i] + a_col_r[i / 4] * b_row_r[i % 4];
                k_r <= k_r + 8'd1;
            end
            if (((next_s == RD_A) && (state_r != RD_A)) || ((next_s == RD_B) && (state_r != RD_B)))
                arvalid_r <= 1'b1;
            else if (arready) arvalid_r <= 1'b0;
            if ((next_s == WR_AW) && (state_r != WR_AW)) awvalid_r <= 1'b1;
            else if (awready) awvalid_r <= 1'b0;
            if ((next_s == WR_W) && (state_r != WR_W)) wvalid_r <= 1'b1;
            else if (w_fire_s && (beat_r == 4'd15)) wvalid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mme_top.sv
// Directed bench for mme_top: APB host tasks plus a word-addressed AXI memory model.
module tb_mme_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  awid, awlen, wid, wstrb, bid, arid, arlen, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] ma [4][16];
    logic [31:0] mb [16][4];
    logic [31:0] exp_c [16];
    logic        ar_stall = 1'b0, aw_stall = 1'b0, w_stall = 1'b0, r_toggle = 1'b0;

    int          rd_left;
    logic [31:0] rd_addr, wr_addr, araddr_q, awaddr_q, wdata_q;
    logic        ar_fire, r_fire, aw_fire, w_fire, b_fire, wlast_q, b_pend, r_phase;

    always #5 clk = ~clk;

    mme_top dut (
        .clk(clk), .rst_n(rst_n),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // AXI memory slave: commits last edge's handshakes, then drives for the next edge
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0; rid = 4'd0; rresp = 2'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 4'd0; bresp = 2'd0;
        rd_left = 0; b_pend = 1'b0; r_phase = 1'b0;
        ar_fire = 1'b0; r_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_left = 0; b_pend = 1'b0;
                ar_fire = 1'b0; r_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
                arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            end else begin
                if (ar_fire) begin rd_addr = araddr_q; rd_left = 4; end
                if (r_fire) begin rd_addr = rd_addr + 32'd4; rd_left = rd_left - 1; end
                if (aw_fire) wr_addr = awaddr_q;
                if (w_fire) begin
                    mem[wr_addr[13:2]] = wdata_q;
                    wr_addr = wr_addr + 32'd4;
                    if (wlast_q) b_pend = 1'b1;
                end
                if (b_fire) b_pend = 1'b0;
                r_phase = ~r_phase;
                arready = arvalid && !ar_stall && (rd_left == 0);
                rvalid  = (rd_left > 0) && (!r_toggle || r_phase);
                rdata   = mem[rd_addr[13:2]];
                rlast   = (rd_left == 1);
                awready = awvalid && !aw_stall;
                wready  = wvalid && !w_stall;
                bvalid  = b_pend;
                ar_fire = arvalid && arready; araddr_q = araddr;
                r_fire  = rvalid && rready;
                aw_fire = awvalid && awready; awaddr_q = awaddr;
                w_fire  = wvalid && wready; wdata_q = wdata; wlast_q = wlast;
                b_fire  = bvalid && bready;
            end
        end
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk); penable = 1'b1;
        #1 d = prdata;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        logic [31:0] s;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            apb_read(32'h210, s);
            if (s[0]) begin ok = 1'b1; break; end
        end
    endtask

    // Fill A (column-major at 0x0), B (row-major at 0x1000), C area, and the reference product
    task automatic load_mats(input int w, input int mode);
        logic [31:0] sum;
        for (int k = 0; k < w; k++) begin
            for (int i = 0; i < 4; i++) begin
                ma[i][k] = (mode == 1) ? 32'hFFFF_FFFF : 32'($urandom_range(255));
                mb[k][i] = (mode == 1) ? 32'd2 : 32'($urandom_range(255));
                mem[4 * k + i] = ma[i][k];
                mem[32'h400 + 4 * k + i] = mb[k][i];
            end
        end
        for (int i = 0; i < 16; i++) begin
            sum = 32'd0;
            for (int k = 0; k < w; k++) sum = sum + ma[i / 4][k] * mb[k][i % 4];
            exp_c[i] = sum;
            mem[32'h800 + i] = 32'hDEAD_BEEF;
        end
    endtask

    task automatic setup_job(input int w);
        apb_write(32'h100, 32'(w));
        apb_write(32'h200, 32'h0000_0000);
        apb_write(32'h204, 32'h0000_1000);
        apb_write(32'h208, 32'h0000_2000);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({arvalid, awvalid, wvalid, pready, pslverr} !== 5'b00010) begin
            failures++; $display("FAIL reset_outputs: got %b expected 00010", {arvalid, awvalid, wvalid, pready, pslverr});
        end
        apb_read(32'h000, d); checks++;
        if (d !== 32'h0001_0000) begin failures++; $display("FAIL ip_ver: got %h expected 00010000", d); end
        apb_read(32'h210, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL reset_status: got %h expected 00000001", d); end
        apb_read(32'h20C, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL cmd_read: got %h expected 00000000", d); end
        apb_read(32'h100, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_cfg: got %h expected 00000000", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        logic [31:0] addrs [4] = '{32'h100, 32'h200, 32'h204, 32'h208};
        logic [31:0] vals  [4] = '{32'd4, 32'd0, 32'h1000, 32'h2000};
        for (int i = 0; i < 4; i++) apb_write(addrs[i], vals[i]);
        for (int i = 0; i < 4; i++) begin
            apb_read(addrs[i], d); checks++;
            if (d !== vals[i]) begin failures++; $display("FAIL reg_rw[%0h]: got %h expected %h", addrs[i], d, vals[i]); end
        end
        apb_write(32'h300, 32'h1234_5678);
        apb_read(32'h300, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL unmapped: got %h expected 00000000", d); end
    endtask

    task automatic test_matmul(input int w, input int mode);
        logic [31:0] d;
        logic ok;
        load_mats(w, mode);
        setup_job(w);
        apb_write(32'h20C, 32'd1);
        apb_read(32'h210, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL busy_status W=%0d: got %h expected 00000000", w, d); end
        wait_done(ok); checks++;
        if (!ok) begin failures++; $display("FAIL done_timeout W=%0d: got 0 expected 1", w); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[32'h800 + i] !== exp_c[i]) begin
                failures++; $display("FAIL c_word W=%0d mode=%0d [%0d]: got %h expected %h", w, mode, i, mem[32'h800 + i], exp_c[i]);
            end
        end
    endtask

    task automatic test_zero_w();
        logic ok;
        load_mats(0, 0);
        setup_job(0);
        apb_write(32'h20C, 32'd1);
        wait_done(ok); checks++;
        if (!ok) begin failures++; $display("FAIL zero_w_timeout: got 0 expected 1"); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[32'h800 + i] !== 32'd0) begin
                failures++; $display("FAIL zero_w_word[%0d]: got %h expected 00000000", i, mem[32'h800 + i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0, d0, d;
        logic ok;
        load_mats(4, 0);
        setup_job(4);
        ar_stall = 1'b1; aw_stall = 1'b1; w_stall = 1'b1; r_toggle = 1'b1;
        apb_write(32'h20C, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin if (arvalid) begin ok = 1'b1; break; end @(negedge clk); end
        checks++;
        if (!ok) begin failures++; $display("FAIL arvalid_timeout: got 0 expected 1"); end
        a0 = araddr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); checks++;
            if (!arvalid || araddr !== a0) begin failures++; $display("FAIL ar_stable: got %b/%h expected 1/%h", arvalid, araddr, a0); end
        end
        apb_write(32'h20C, 32'd1);
        apb_write(32'h100, 32'd8);
        ar_stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin if (awvalid) begin ok = 1'b1; break; end @(negedge clk); end
        checks++;
        if (!ok) begin failures++; $display("FAIL awvalid_timeout: got 0 expected 1"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); checks++;
            if (!awvalid || awaddr !== 32'h2000) begin failures++; $display("FAIL aw_stable: got %b/%h expected 1/00002000", awvalid, awaddr); end
        end
        aw_stall = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin if (wvalid) begin ok = 1'b1; break; end @(negedge clk); end
        checks++;
        if (!ok) begin failures++; $display("FAIL wvalid_timeout: got 0 expected 1"); end
        d0 = exp_c[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); checks++;
            if (!wvalid || wdata !== d0) begin failures++; $display("FAIL w_stable: got %b/%h expected 1/%h", wvalid, wdata, d0); end
        end
        w_stall = 1'b0;
        wait_done(ok); checks++;
        if (!ok) begin failures++; $display("FAIL stall_done_timeout: got 0 expected 1"); end
        r_toggle = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[32'h800 + i] !== exp_c[i]) begin
                failures++; $display("FAIL stall_c_word[%0d]: got %h expected %h", i, mem[32'h800 + i], exp_c[i]);
            end
        end
        apb_read(32'h100, d); checks++;
        if (d !== 32'd8) begin failures++; $display("FAIL busy_cfg_write: got %h expected 00000008", d); end
    endtask

    task automatic test_midreset();
        logic [31:0] d;
        logic ok;
        setup_job(4);
        ar_stall = 1'b1;
        apb_write(32'h20C, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin if (arvalid) begin ok = 1'b1; break; end @(negedge clk); end
        checks++;
        if (!ok) begin failures++; $display("FAIL midreset_arvalid_timeout: got 0 expected 1"); end
        #2 rst_n = 1'b0;
        #1 checks++;
        if (arvalid !== 1'b0) begin failures++; $display("FAIL async_reset_arvalid: got %b expected 0", arvalid); end
        ar_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apb_read(32'h210, d); checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL midreset_status: got %h expected 00000001", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_matmul(4, 0);
        test_matmul(8, 0);
        test_matmul(12, 0);
        test_matmul(16, 0);
        test_matmul(4, 1);
        test_zero_w();
        test_stall();
        test_midreset();
        test_matmul(4, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
